// File: rtl/mini_cpu_datapath.sv
// Single-bus 32-bit CPU datapath: sixteen general registers plus PC, HI, LO,
// InPort, MDR, Y and a 64-bit Z pair share one internal bus. The ALU takes
// A from Y and B from the bus and produces a 64-bit result for Z.
module mini_cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             Read,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             HIout, LOout, Zhighout, Zlowout,
  input  logic             PCout, MDRout, InPortout, Yout,
  input  logic             R0in,  R1in,  R2in,  R3in,
  input  logic             R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in,
  input  logic             R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, ZHighin, Zlowin,
  input  logic             IncPC, MDRin, InPortin, Yin,
  output logic [WIDTH-1:0] BusOut,
  output logic [WIDTH-1:0] mdrData,
  output logic [WIDTH-1:0] BusMuxInR0,
  output logic [WIDTH-1:0] BusMuxInR1,
  output logic [WIDTH-1:0] BusMuxInR2,
  output logic [WIDTH-1:0] BusMuxInYOut
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND = 5'b00010,
    OP_OR   = 5'b00011, OP_SHR  = 5'b00100, OP_SHRA = 5'b00101,
    OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL = 5'b01000,
    OP_NEG  = 5'b01001, OP_MUL  = 5'b01010, OP_DIV = 5'b01011,
    OP_NOT  = 5'b01100
  } alu_op_e;

  logic [WIDTH-1:0]   r_gpr [16];
  logic [WIDTH-1:0]   r_hi, r_lo, r_pc, r_mdr, r_inport, r_y;
  logic [2*WIDTH-1:0] r_z;

  logic [15:0]        w_rout, w_rin;
  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_a, w_b;
  logic [SH_W-1:0]    w_sh, w_shc;
  logic [WIDTH-1:0]   w_ror, w_rol, w_quot, w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_lo, w_res_hi;

  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Bus mux: later assignments win, so checks run from lowest to highest priority.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_bus = '0;
    if (Yout)      w_bus = r_y;
    if (InPortout) w_bus = r_inport;
    if (MDRout)    w_bus = r_mdr;
    if (PCout)     w_bus = r_pc;
    if (Zlowout)   w_bus = r_z[WIDTH-1:0];
    if (Zhighout)  w_bus = r_z[2*WIDTH-1:WIDTH];
    if (LOout)     w_bus = r_lo;
    if (HIout)     w_bus = r_hi;
    for (int i = 15; i >= 0; i--) begin
      if (w_rout[i]) w_bus = r_gpr[i];
    end
  end

  // ALU operands and the wide/shifted intermediate results.
  assign w_a    = r_y;
  assign w_b    = w_bus;
  assign w_sh   = w_b[SH_W-1:0];
  assign w_shc  = SH_W'(0) - w_sh;
  assign w_ror  = (w_a >> w_sh) | (w_a << w_shc);
  assign w_rol  = (w_a << w_sh) | (w_a >> w_shc);
  assign w_prod = $signed({{WIDTH{w_a[WIDTH-1]}}, w_a}) *
                  $signed({{WIDTH{w_b[WIDTH-1]}}, w_b});
  assign w_quot = $signed(w_a) / $signed(w_b);
  assign w_rem  = $signed(w_a) % $signed(w_b);

  // ALU operation select; only mul and div produce a nonzero high word.
  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    case (op)
      OP_ADD:  w_res_lo = w_a + w_b;
      OP_SUB:  w_res_lo = w_a - w_b;
      OP_AND:  w_res_lo = w_a & w_b;
      OP_OR:   w_res_lo = w_a | w_b;
      OP_SHR:  w_res_lo = w_a >> w_sh;
      OP_SHRA: w_res_lo = $signed(w_a) >>> w_sh;
      OP_SHL:  w_res_lo = w_a << w_sh;
      OP_ROR:  w_res_lo = w_ror;
      OP_ROL:  w_res_lo = w_rol;
      OP_NEG:  w_res_lo = -w_b;
      OP_MUL:  {w_res_hi, w_res_lo} = w_prod;
      OP_DIV: begin
        // Divide by zero: all-ones quotient, dividend passed through as remainder.
        if (w_b == '0) begin
          w_res_lo = '1;
          w_res_hi = w_a;
        end else begin
          w_res_lo = w_quot;
          w_res_hi = w_rem;
        end
      end
      OP_NOT:  w_res_lo = ~w_b;
      default: ;
    endcase
  end

  // Register file and special registers: synchronous clear, then strobed loads.
  always_ff @(posedge Clock) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge bus, which is what lets a register drive and reload itself.
    if (clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_z      <= '0;
      r_pc     <= '0;
      r_mdr    <= '0;
      r_inport <= '0;
      r_y      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_rin[i]) r_gpr[i] <= w_bus;
      end
      if (HIin)     r_hi                   <= w_bus;
      if (LOin)     r_lo                   <= w_bus;
      if (ZHighin)  r_z[2*WIDTH-1:WIDTH]   <= w_res_hi;
      if (Zlowin)   r_z[WIDTH-1:0]         <= w_res_lo;
      if (IncPC)    r_pc                   <= r_pc + WIDTH'(1);
      if (MDRin)    r_mdr                  <= Read ? Mdatain : w_bus;
      if (InPortin) r_inport               <= w_bus;
      if (Yin)      r_y                    <= w_bus;
    end
  end

  assign BusOut       = w_bus;
  assign mdrData      = r_mdr;
  assign BusMuxInR0   = r_gpr[0];
  assign BusMuxInR1   = r_gpr[1];
  assign BusMuxInR2   = r_gpr[2];
  assign BusMuxInYOut = r_y;

endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Self-checking bench for mini_cpu_datapath. Expected values are queued on a
// scoreboard as stimulus is driven and popped when the result is observed.
module tb_mini_cpu_datapath;

  logic        clk;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [15:0] rout, rin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic        HIin, LOin, ZHighin, Zlowin, IncPC, MDRin, InPortin, Yin;
  logic [31:0] BusOut, mdrData, r0, r1, r2, yv;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  errors = 0;
  int  checks = 0;

  localparam logic [4:0]  T_OP [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                        5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd31};
  localparam logic [31:0] T_LO [14] = '{32'h80000004, 32'h7FFFFFFC, 32'h00000000,
                                        32'h80000004, 32'h08000000, 32'hF8000000,
                                        32'h00000000, 32'h08000000, 32'h00000008,
                                        32'hFFFFFFFC, 32'h00000000, 32'hE0000000,
                                        32'hFFFFFFFB, 32'h00000000};
  localparam logic [31:0] T_HI [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                        32'h0, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h0,
                                        32'h0, 32'h0};

  mini_cpu_datapath #(.WIDTH(32)) dut (
    .Clock(clk), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .IncPC(IncPC), .MDRin(MDRin), .InPortin(InPortin), .Yin(Yin),
    .BusOut(BusOut), .mdrData(mdrData),
    .BusMuxInR0(r0), .BusMuxInR1(r1), .BusMuxInR2(r2), .BusMuxInYOut(yv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rout = '0; rin = '0; Read = 1'b0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0;
    PCout = 0; MDRout = 0; InPortout = 0; Yout = 0;
    HIin = 0; LOin = 0; ZHighin = 0; Zlowin = 0;
    IncPC = 0; MDRin = 0; InPortin = 0; Yin = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_val(input string n, input logic [31:0] v);
    sb_t t;
    t.name = n;
    t.exp  = v;
    sb.push_back(t);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    cyc();
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; rin[n] = 1'b1;
    cyc();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    cyc();
  endtask

  task automatic run_alu(input logic [4:0] code);
    op = code; rout[2] = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1;
    cyc();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1; cyc(); clear = 1'b0;
    load_reg(1, 32'hA5A5_0001);
    load_y(32'h1234_5678);
    load_mdr(32'h0000_00EE);
    IncPC = 1'b1; cyc();
    IncPC = 1'b1; cyc();
    // clear must win over a simultaneous MDR -> R2 transfer
    clear = 1'b1; MDRout = 1'b1; rin[2] = 1'b1; Yin = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    expect_val("reset_r0", 32'h0);  expect_val("reset_r1", 32'h0);
    expect_val("reset_r2", 32'h0);  expect_val("reset_y", 32'h0);
    expect_val("reset_mdr", 32'h0); expect_val("reset_bus_idle", 32'h0);
    e = sb.pop_front(); checks++;
    if (r0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r0, e.exp); end
    e = sb.pop_front(); checks++;
    if (r1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r1, e.exp); end
    e = sb.pop_front(); checks++;
    if (r2 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r2, e.exp); end
    e = sb.pop_front(); checks++;
    if (yv !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, yv, e.exp); end
    e = sb.pop_front(); checks++;
    if (mdrData !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, mdrData, e.exp); end
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    PCout = 1'b1; #1;
    expect_val("reset_pc", 32'h0);
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
  endtask

  task automatic test_pc();
    for (int i = 0; i < 3; i++) begin
      IncPC = 1'b1; cyc();
    end
    PCout = 1'b1; #1;
    expect_val("pc_inc3", 32'd3);
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
  endtask

  task automatic test_multiply();
    load_mdr(32'd12);
    expect_val("mul_mdr12", 32'd12);
    e = sb.pop_front(); checks++;
    if (mdrData !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, mdrData, e.exp); end
    MDRout = 1'b1; Yin = 1'b1; cyc();
    expect_val("mul_y12", 32'd12);
    e = sb.pop_front(); checks++;
    if (yv !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, yv, e.exp); end
    load_reg(2, 32'd5);
    expect_val("mul_r2_5", 32'd5);
    e = sb.pop_front(); checks++;
    if (r2 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r2, e.exp); end
    run_alu(5'b01010);
    expect_val("mul_r1_lo", 32'd60);
    expect_val("mul_r0_hi", 32'd0);
    Zlowout = 1'b1; rin[1] = 1'b1; cyc();
    e = sb.pop_front(); checks++;
    if (r1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r1, e.exp); end
    Zhighout = 1'b1; rin[0] = 1'b1; cyc();
    e = sb.pop_front(); checks++;
    if (r0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r0, e.exp); end
  endtask

  task automatic test_signed_mul();
    load_y(32'hFFFF_FFFD);
    load_reg(2, 32'd7);
    run_alu(5'b01010);
    expect_val("smul_lo", 32'hFFFF_FFEB);
    expect_val("smul_hi", 32'hFFFF_FFFF);
    Zlowout = 1'b1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    Zlowout = 1'b0; Zhighout = 1'b1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
  endtask

  task automatic test_divide();
    logic [31:0] ys [3] = '{32'd17, 32'hFFFF_FFEF, 32'd17};
    logic [31:0] bs [3] = '{32'd5, 32'd5, 32'd0};
    logic [31:0] qs [3] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] rs [3] = '{32'd2, 32'hFFFF_FFFE, 32'd17};
    for (int i = 0; i < 3; i++) begin
      load_y(ys[i]);
      load_reg(2, bs[i]);
      run_alu(5'b01011);
      expect_val($sformatf("div%0d_quot", i), qs[i]);
      expect_val($sformatf("div%0d_rem", i), rs[i]);
      Zlowout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      Zlowout = 1'b0; Zhighout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      idle();
    end
    // Z halves load independently: Y=17, B=0 left Z = {17, FFFFFFFF}
    op = 5'b00000; rout[2] = 1'b1; Zlowin = 1'b1; cyc();
    op = 5'b00001; rout[2] = 1'b1; ZHighin = 1'b1; cyc();
    expect_val("zsplit_lo_only", 32'd17);
    expect_val("zsplit_hi_only", 32'd0);
    Zlowout = 1'b1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    Zlowout = 1'b0; Zhighout = 1'b1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
  endtask

  task automatic test_sub_shift();
    load_y(32'd10);
    load_reg(2, 32'd3);
    run_alu(5'b00001);
    expect_val("sub_10_3", 32'd7);
    Zlowout = 1'b1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
    load_y(32'h8000_0000);
    load_reg(2, 32'd4);
    for (int i = 0; i < 14; i++) begin
      run_alu(T_OP[i]);
      expect_val($sformatf("alu_op%0d_lo", T_OP[i]), T_LO[i]);
      expect_val($sformatf("alu_op%0d_hi", T_OP[i]), T_HI[i]);
      Zlowout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      Zlowout = 1'b0; Zhighout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      idle();
    end
  endtask

  task automatic test_priority();
    load_reg(0, 32'h0000_0111);
    load_reg(1, 32'h0000_0222);
    load_mdr(32'h0000_0333); MDRout = 1'b1; HIin = 1'b1; cyc();
    load_mdr(32'h0000_0444); MDRout = 1'b1; LOin = 1'b1; InPortin = 1'b1; cyc();
    load_y(32'h0000_0555);
    load_mdr(32'h0000_0666);
    expect_val("prio_r0_over_all", 32'h111);
    expect_val("prio_hi_over_lo", 32'h333);
    expect_val("prio_zhigh_over_pc", 32'h0);
    expect_val("prio_mdr_over_inport", 32'h666);
    expect_val("prio_inport_over_y", 32'h444);
    rout = 16'hFFFF; HIout = 1; Yout = 1; MDRout = 1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle(); HIout = 1; LOout = 1; Zlowout = 1; Yout = 1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle(); Zhighout = 1; PCout = 1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle(); MDRout = 1; InPortout = 1; Yout = 1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle(); InPortout = 1; Yout = 1; #1;
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    idle();
  endtask

  task automatic test_self_reload();
    rout[1] = 1'b1; rin[1] = 1'b1; rin[0] = 1'b1; cyc();
    expect_val("self_r1_holds", 32'h222);
    expect_val("self_r0_copy", 32'h222);
    e = sb.pop_front(); checks++;
    if (r1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r1, e.exp); end
    e = sb.pop_front(); checks++;
    if (r0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r0, e.exp); end
  endtask

  task automatic test_mdr_select();
    load_reg(2, 32'd5);
    load_mdr(32'h0000_0099);
    Mdatain = 32'h0000_DEAD; Read = 1'b0; MDRin = 1'b1; rout[2] = 1'b1;
    @(posedge clk); #1; idle();
    Mdatain = 32'h0000_BEEF;
    expect_val("mdr_from_bus", 32'd5);
    e = sb.pop_front(); checks++;
    if (mdrData !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, mdrData, e.exp); end
    for (int i = 0; i < 3; i++) cyc();
    expect_val("hold_bus_idle", 32'h0);
    expect_val("hold_r0", 32'h222); expect_val("hold_r1", 32'h222);
    expect_val("hold_r2", 32'd5);   expect_val("hold_y", 32'h555);
    expect_val("hold_mdr", 32'd5);
    e = sb.pop_front(); checks++;
    if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
    e = sb.pop_front(); checks++;
    if (r0 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r0, e.exp); end
    e = sb.pop_front(); checks++;
    if (r1 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r1, e.exp); end
    e = sb.pop_front(); checks++;
    if (r2 !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, r2, e.exp); end
    e = sb.pop_front(); checks++;
    if (yv !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, yv, e.exp); end
    e = sb.pop_front(); checks++;
    if (mdrData !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, mdrData, e.exp); end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b;
    logic [4:0]  code;
    longint      p;
    int          ai, bi;
    logic [31:0] lo, hi;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i == 7) ? 32'd0 : $urandom();
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      case (i % 4)
        0: code = 5'b00000;
        1: code = 5'b00001;
        2: code = 5'b01010;
        default: code = 5'b01011;
      endcase
      if (i == 7) code = 5'b01011;
      ai = int'(a);
      bi = int'(b);
      hi = 32'h0;
      case (code)
        5'b00000: lo = a + b;
        5'b00001: lo = a - b;
        5'b01010: begin
          p  = longint'(ai) * longint'(bi);
          lo = p[31:0];
          hi = p[63:32];
        end
        default: begin
          if (bi == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
          else begin lo = 32'(ai / bi); hi = 32'(ai % bi); end
        end
      endcase
      load_y(a);
      load_reg(2, b);
      run_alu(code);
      expect_val($sformatf("rand%0d_op%0d_lo", i, code), lo);
      expect_val($sformatf("rand%0d_op%0d_hi", i, code), hi);
      Zlowout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      Zlowout = 1'b0; Zhighout = 1'b1; #1;
      e = sb.pop_front(); checks++;
      if (BusOut !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, BusOut, e.exp); end
      idle();
    end
  endtask

  initial begin
    idle();
    clear   = 1'b0;
    op      = 5'b0;
    Mdatain = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_pc();
    test_multiply();
    test_signed_mul();
    test_divide();
    test_sub_shift();
    test_priority();
    test_self_reload();
    test_mdr_select();
    test_random_alu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
